idex_pipe_stage: RTL
====================

Name: idex_pipe_stage

Overview:
- Parametrised, elastic ID/EX pipeline stage: decoded control, opcode, PC, operands, immediate and destination register pass from decode to execute.
- Two-entry skid buffer with valid/ready handshakes on both sides; FIFO order preserved.
- Adds synchronous flush (branch/jump kill) and load-use bubble insertion.
- Replaces the fixed-width, enable-only ID/EX register.

Parameters:
DATA_W, 32, width of Pc, R1, R2, I
RD_W, 5, destination register index width
OP_W, 6, opcode width
CTRL_W, 10, packed control vector width (bit map in idex_pkg)
CNT_W, 16, perf counter width (IDEX_PERF_EN only)

Ports:
Clk  in  1  clock, rising edge
Clrn  in  1  async active-low reset
In_valid  in  1  decode presents an instruction
In_ready  out  1  stage accepts this cycle
Flush  in  1  kill all held and incoming entries
Bubble  in  1  insert a NOP instead of consuming input
In_ctrl  in  CTRL_W  packed control: Wreg, Reg2reg, Wmem, Aluqb, Aluc[1:0], FwdA[1:0], FwdB[1:0]
In_op  in  OP_W  opcode
In_pc, In_r1, In_r2, In_i  in  DATA_W  PC, operand A, operand B, immediate
In_rd  in  RD_W  destination register
Out_valid  out  1  head entry valid
Out_ready  in  1  execute consumes head
Out_ctrl, Out_op, Out_pc, Out_r1, Out_r2, Out_i, Out_rd  out  as inputs  head entry fields

Behaviour:
- Clk is the single clock. Clrn is asynchronous, active-low: when low, state is EMPTY, both slots clear, and every output except In_ready is 0.
- Occupancy FSM: EMPTY, ONE, TWO.
  - Slot H (head) drives Out_*. Slot S (skid) holds the second entry.
- In_ready = (state != TWO) & ~Bubble & ~Flush.
  - Depends only on registered state plus two inputs; no path from Out_ready.
- acc = In_valid & In_ready. deq = Out_valid & Out_ready. Out_valid = (state != EMPTY).
- Latency: a beat accepted in cycle n appears on Out_* in cycle n+1 when the stage was EMPTY, or when it was ONE with a dequeue in n.
- Transitions, with Flush = 0:
  - EMPTY: acc loads H and goes to ONE.
  - ONE:
    - acc & deq: H takes the input; stay ONE.
    - acc & ~deq: S takes the input; go TWO.
    - ~acc & deq: go EMPTY.
  - TWO: deq moves S to H and goes to ONE; no accept possible.
- Bubble (Flush = 0, state != TWO): a NOP entry is enqueued exactly as an accepted beat would be.
  - NOP fields: ctrl = 0, op = 0, rd = 0, data = 0.
  - The input is not consumed.
  - Bubble in TWO is a no-op; the requester keeps Bubble high until it takes effect.
- Flush: highest priority.
  - Next state EMPTY; H and S ctrl cleared.
  - Input presented that cycle is dropped.
  - Output deq in the flush cycle still completes; execute sees the head once.
- Bubble and Flush together: Flush wins; no NOP is inserted.
- Empty slots always present ctrl = 0, so Out_ctrl = 0 whenever Out_valid = 0 (no spurious Wreg/Wmem).
- No combinational path from any In_* data to Out_*.

Optional Feature:
- Macro IDEX_PERF_EN.
- When defined, adds two outputs, each CNT_W bits:
  - Stall_cnt: increments each cycle In_valid & ~In_ready & ~Flush.
  - Bubble_cnt: increments each cycle a NOP is enqueued.
- Both saturate at all-ones and clear only on Clrn.
- When undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Package idex_pkg:
  - Control bit indices: CTRL_WREG = 0, CTRL_REG2REG = 1, CTRL_WMEM = 2, CTRL_ALUQB = 3, CTRL_ALUC = 5:4, CTRL_FWDA = 7:6, CTRL_FWDB = 9:8.
  - Default CTRL_W = 10.
  - FSM state encoding EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2.
  - NOP opcode constant OP_NOP = 0.
- Sub-module idex_slot:
  - One parametrised entry register: load-enable plus synchronous ctrl-clear, async Clrn.
  - Instantiated twice (H, S).

Test Plan:
- Reset: Clrn = 0 mid-stream with the stage in state TWO -> Out_valid = 0, Out_ctrl = 0 immediately; after release In_ready = 1.
- Stream: Out_ready = 1, back-to-back beats Pc = 0x100, 0x104, 0x108 -> each appears one cycle later in order; In_ready stays 1; no loss or duplication.
- Backpressure: Out_ready = 0 while sending Pc = 0x200, 0x204 -> state TWO, In_ready = 0. Release Out_ready -> 0x200 then 0x204 in consecutive cycles; In_ready returns to 1 the cycle after the first dequeue.
- Bubble: In_valid = 1 with Pc = 0x300, Bubble = 1 for one cycle -> NOP entry emitted with Out_ctrl = 0, Out_rd = 0; 0x300 is held upstream and emitted next.
- Flush: state TWO, Out_ready = 1, Flush = 1 with a new beat present -> head dequeued once; next cycle Out_valid = 0; skid and incoming beats never appear.
- Perf (IDEX_PERF_EN, CNT_W = 4): 20 stall cycles -> Stall_cnt = 15 (saturated); 3 bubbles -> Bubble_cnt = 3.

Source files
------------

// File: rtl/idex_pkg.sv
// ---------------------------------------------------------------------------
// idex_pkg
// Shared definitions for the ID/EX elastic pipeline stage:
//   - bit positions inside the packed control vector
//   - occupancy FSM state encoding
//   - NOP opcode
// ---------------------------------------------------------------------------
package idex_pkg;

    localparam int CTRL_W_DEF   = 10;

    localparam int CTRL_WREG    = 0;
    localparam int CTRL_REG2REG = 1;
    localparam int CTRL_WMEM    = 2;
    localparam int CTRL_ALUQB   = 3;
    localparam int CTRL_ALUC_LO = 4;
    localparam int CTRL_ALUC_HI = 5;
    localparam int CTRL_FWDA_LO = 6;
    localparam int CTRL_FWDA_HI = 7;
    localparam int CTRL_FWDB_LO = 8;
    localparam int CTRL_FWDB_HI = 9;

    localparam int OP_NOP       = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } idex_state_e;

endpackage

// File: rtl/idex_pipe_stage_if.sv
// ---------------------------------------------------------------------------
// idex_pipe_stage_if
// Valid/ready beat bus carrying one decoded instruction.
//   valid, ready : handshake (transfer when both high)
//   ctrl         : packed control vector (bit map in idex_pkg)
//   op           : opcode
//   pc, r1, r2   : PC and the two operands
//   imm          : immediate
//   rd           : destination register index
// master drives the beat, slave returns ready.
// ---------------------------------------------------------------------------
interface idex_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int OP_W   = 6,
    parameter int CTRL_W = 10
) ();
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] imm;
    logic [RD_W-1:0]   rd;

    modport master (output valid, ctrl, op, pc, r1, r2, imm, rd, input ready);
    modport slave  (input valid, ctrl, op, pc, r1, r2, imm, rd, output ready);
endinterface

// File: rtl/idex_slot.sv
// ---------------------------------------------------------------------------
// idex_slot
// One entry register of the ID/EX stage.
//   clk, clrn : clock, async active-low reset (clears everything)
//   load      : capture d_ctrl / d_pl
//   clr       : synchronous clear of the control field only (wins over load)
//   q_ctrl    : held control vector
//   q_pl      : held payload (opcode, PC, operands, immediate, rd)
// Only ctrl is cleared on a kill: a stale payload is harmless once every
// write-enable bit in ctrl is zero.
// ---------------------------------------------------------------------------
module idex_slot #(
    parameter int CTRL_W = 10,
    parameter int PL_W   = 139
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [PL_W-1:0]   d_pl,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [PL_W-1:0]   q_pl
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_ctrl <= '0;
            q_pl   <= '0;
        end else begin
            if (clr) begin
                q_ctrl <= '0;
            end else if (load) begin
                q_ctrl <= d_ctrl;
            end
            if (load && !clr) begin
                q_pl <= d_pl;
            end
        end
    end

endmodule

// File: rtl/idex_pipe_stage.sv
// ---------------------------------------------------------------------------
// idex_pipe_stage
// Elastic ID/EX pipeline stage: two-entry skid buffer (head H, skid S) with
// synchronous flush and load-use bubble insertion.
//   clk, clrn  : clock, async active-low reset
//   in_bus     : beats from decode (slave side)
//   out_bus    : head entry towards execute (master side)
//   flush      : kill held and incoming entries (highest priority)
//   bubble     : enqueue a NOP instead of consuming the input
//   stall_cnt  : (IDEX_PERF_EN) cycles with input waiting but not accepted
//   bubble_cnt : (IDEX_PERF_EN) NOP entries enqueued
// Optional feature macro: IDEX_PERF_EN (adds CNT_W and the two counters).
//
// state | meaning
// EMPTY | no entry held, out valid low
// ONE   | H holds the head entry
// TWO   | H holds head, S holds the next entry; input blocked
// ---------------------------------------------------------------------------
module idex_pipe_stage
    import idex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int OP_W   = 6,
    parameter int CTRL_W = CTRL_W_DEF
`ifdef IDEX_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic clk,
    input  logic clrn,
    idex_pipe_stage_if.slave  in_bus,
    idex_pipe_stage_if.master out_bus,
    input  logic flush,
    input  logic bubble
`ifdef IDEX_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    localparam int PL_W = OP_W + 4 * DATA_W + RD_W;

    idex_state_e state_q, state_d;

    logic              in_ready;
    logic              acc, deq, nop_enq, enq;
    logic              h_load, h_clr, s_load, s_clr, h_from_s;
    logic [CTRL_W-1:0] enq_ctrl, h_d_ctrl, h_ctrl, s_ctrl;
    logic [PL_W-1:0]   enq_pl, h_d_pl, h_pl, s_pl;

    // Ready is a function of registered state and two side inputs only, so
    // out_bus.ready never reaches in_bus.ready combinationally.
    assign in_ready = (state_q != TWO) && !bubble && !flush;
    assign acc      = in_bus.valid && in_ready;
    assign deq      = out_bus.valid && out_bus.ready;
    assign nop_enq  = bubble && !flush && (state_q != TWO);
    assign enq      = acc || nop_enq;

    assign enq_ctrl = nop_enq ? '0 : in_bus.ctrl;
    assign enq_pl   = nop_enq ? {OP_W'(OP_NOP), {(4 * DATA_W + RD_W){1'b0}}}
                              : {in_bus.op, in_bus.pc, in_bus.r1, in_bus.r2,
                                 in_bus.imm, in_bus.rd};

    assign h_d_ctrl = h_from_s ? s_ctrl : enq_ctrl;
    assign h_d_pl   = h_from_s ? s_pl   : enq_pl;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        h_load   = 1'b0;
        h_clr    = 1'b0;
        s_load   = 1'b0;
        s_clr    = 1'b0;
        h_from_s = 1'b0;
        if (flush) begin
            // A dequeue in this cycle still completes; everything else dies.
            state_d = EMPTY;
            h_clr   = 1'b1;
            s_clr   = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (enq) begin
                        h_load  = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (enq && deq) begin
                        h_load = 1'b1;
                    end else if (enq) begin
                        s_load  = 1'b1;
                        state_d = TWO;
                    end else if (deq) begin
                        h_clr   = 1'b1;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deq) begin
                        h_load   = 1'b1;
                        h_from_s = 1'b1;
                        s_clr    = 1'b1;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    h_clr   = 1'b1;
                    s_clr   = 1'b1;
                end
            endcase
        end
    end

    idex_slot #(.CTRL_W(CTRL_W), .PL_W(PL_W)) u_slot_h (
        .clk    (clk),
        .clrn   (clrn),
        .load   (h_load),
        .clr    (h_clr),
        .d_ctrl (h_d_ctrl),
        .d_pl   (h_d_pl),
        .q_ctrl (h_ctrl),
        .q_pl   (h_pl)
    );

    idex_slot #(.CTRL_W(CTRL_W), .PL_W(PL_W)) u_slot_s (
        .clk    (clk),
        .clrn   (clrn),
        .load   (s_load),
        .clr    (s_clr),
        .d_ctrl (enq_ctrl),
        .d_pl   (enq_pl),
        .q_ctrl (s_ctrl),
        .q_pl   (s_pl)
    );

    assign in_bus.ready  = in_ready;
    assign out_bus.valid = (state_q != EMPTY);
    assign out_bus.ctrl  = h_ctrl;
    assign {out_bus.op, out_bus.pc, out_bus.r1, out_bus.r2,
            out_bus.imm, out_bus.rd} = h_pl;

`ifdef IDEX_PERF_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_bus.valid && !in_ready && !flush && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (nop_enq && !(&bubble_cnt)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
